// File: rtl/nonce_search_pkg.sv
// rtl/nonce_search_pkg.sv - shared widths, score init value and FSM state type for the nonce search controller
package nonce_search_pkg;

    localparam int NONCE_W = 256;
    localparam int HASH_W  = 1024;
    localparam int SCORE_W = 11;

    localparam logic [SCORE_W-1:0] SCORE_INIT = 11'd1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_SCORE_XOR,
        ST_SCORE_CMP
    } state_t;

endpackage

// File: rtl/popcount_1024.sv
// rtl/popcount_1024.sv - combinational 1024-bit population count built as a balanced adder tree
module popcount_1024 (
    input  logic [1023:0] data,
    output logic [10:0]   count
);

    // Level l holds 512>>l partial sums, each l+2 bits wide; level 9 is the root.
    for (genvar l = 0; l < 10; l++) begin : g_lvl
        logic [l+1:0] s [512 >> l];
        for (genvar i = 0; i < (512 >> l); i++) begin : g_node
            if (l == 0) begin : g_leaf
                assign s[i] = {1'b0, data[2*i]} + {1'b0, data[2*i+1]};
            end else begin : g_sum
                assign s[i] = {1'b0, g_lvl[l-1].s[2*i]} + {1'b0, g_lvl[l-1].s[2*i+1]};
            end
        end
    end

    assign count = g_lvl[9].s[0];

endmodule

// File: rtl/nonce_search_controller.sv
// rtl/nonce_search_controller.sv - brute-force nonce search sequencer; optional WAIT watchdog under NONCE_SEARCH_TIMEOUT_EN
module nonce_search_controller
    import nonce_search_pkg::*;
`ifdef NONCE_SEARCH_TIMEOUT_EN
    #(parameter int TIMEOUT_CYCLES = 4096)
`endif
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic [NONCE_W-1:0] nonce_seed_i,
    input  logic [HASH_W-1:0]  target_i,
    input  logic [SCORE_W-1:0] threshold_i,
    output logic               core_start_o,
    output logic [NONCE_W-1:0] core_nonce_o,
    input  logic [HASH_W-1:0]  core_hash_i,
    input  logic               core_ready_i,
    output logic               busy_o,
    output logic               found_o,
    output logic [SCORE_W-1:0] best_score_o,
    output logic [NONCE_W-1:0] best_nonce_o,
    output logic [31:0]        hash_count_o,
    output logic               timeout_o
);

    state_t             state, state_nx;
    logic [NONCE_W-1:0] nonce_q;
    logic [HASH_W-1:0]  diff_q;
    logic [SCORE_W-1:0] best_score_q;
    logic [NONCE_W-1:0] best_nonce_q;
    logic [31:0]        count_q;
    logic               found_q;
    logic               stop_q;
    logic [SCORE_W-1:0] score;
    logic               hit;
    logic               stop_go;
    logic               wait_expired;

    popcount_1024 u_popcount (
        .data  (diff_q),
        .count (score)
    );

    assign hit     = (score <= threshold_i);
    assign stop_go = stop_q | stop_i;

`ifdef NONCE_SEARCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;

    assign wait_expired = (state == ST_WAIT) && !core_ready_i && (wait_cnt == WAIT_LAST);

    // Watchdog: counter restarts on every entry to WAIT, flag is sticky until the next accepted start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == ST_ISSUE) begin
                wait_cnt <= '0;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state == ST_IDLE && start_i) begin
                timeout_q <= 1'b0;
            end else if (wait_expired) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    assign wait_expired = 1'b0;
    assign timeout_o    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode plus the launch strobe and busy flag.
    always_comb begin
        state_nx     = state;
        core_start_o = 1'b0;
        busy_o       = 1'b1;
        case (state)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                core_start_o = 1'b1;
                state_nx     = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_ready_i) begin
                    state_nx = ST_SCORE_XOR;
                end else if (wait_expired) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_SCORE_XOR: begin
                state_nx = ST_SCORE_CMP;
            end
            ST_SCORE_CMP: begin
                state_nx = (hit || stop_go) ? ST_IDLE : ST_ISSUE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Search datapath: nonce, captured hash/diff, best tracking, hash counter, found and stop latches.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            nonce_q      <= '0;
            diff_q       <= '0;
            best_score_q <= SCORE_INIT;
            best_nonce_q <= '0;
            count_q      <= '0;
            found_q      <= 1'b0;
            stop_q       <= 1'b0;
        end else begin
            if (state != ST_IDLE && stop_i) begin
                stop_q <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        nonce_q      <= nonce_seed_i;
                        best_score_q <= SCORE_INIT;
                        best_nonce_q <= '0;
                        count_q      <= '0;
                        found_q      <= 1'b0;
                        stop_q       <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (core_ready_i) begin
                        diff_q <= core_hash_i;
                    end
                end
                ST_SCORE_XOR: begin
                    diff_q <= diff_q ^ target_i;
                end
                ST_SCORE_CMP: begin
                    if (score < best_score_q) begin
                        best_score_q <= score;
                        best_nonce_q <= nonce_q;
                    end
                    if (count_q != 32'hFFFF_FFFF) begin
                        count_q <= count_q + 32'd1;
                    end
                    if (hit) begin
                        found_q <= 1'b1;
                    end else if (!stop_go) begin
                        nonce_q <= nonce_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign core_nonce_o = nonce_q;
    assign found_o      = found_q;
    assign best_score_o = best_score_q;
    assign best_nonce_o = best_nonce_q;
    assign hash_count_o = count_q;

endmodule

// File: doc/nonce_search_controller.md
# nonce_search_controller

Sequencer that drives the Skein-1024 hashing datapath through a brute-force nonce search. It issues one nonce at a time to the hash core and waits for the core's ready pulse. Each returned 1024-bit hash is scored by Hamming distance against a target. The block tracks the best (lowest-distance) nonce and stops on a threshold hit or a stop request. It sits directly above the hashing top level and is the only agent that starts hashes.

## Interface
- NONCE_W, 256, nonce width
- HASH_W, 1024, hash/target width
- SCORE_W, 11, Hamming-distance width (0..1024)
- TIMEOUT_CYCLES, 4096, watchdog limit in WAIT (only with NONCE_SEARCH_TIMEOUT_EN)
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  begin search; sampled only in IDLE
- stop_i  in  1  request stop; latched while busy
- nonce_seed_i  in  NONCE_W  first nonce, sampled with start_i
- target_i  in  HASH_W  target hash; held stable by the user while busy_o
- threshold_i  in  SCORE_W  success limit; hit when score <= threshold_i
- core_start_o  out  1  one-cycle pulse launching a hash
- core_nonce_o  out  NONCE_W  nonce under hash; stable from ISSUE until the next ISSUE
- core_hash_i  in  HASH_W  hash from the core, valid when core_ready_i=1
- core_ready_i  in  1  core result strobe
- busy_o  out  1  high in every state except IDLE
- found_o  out  1  sticky; set on threshold hit, cleared by the next accepted start_i
- best_score_o  out  SCORE_W  lowest distance so far
- best_nonce_o  out  NONCE_W  nonce that produced best_score_o
- hash_count_o  out  32  hashes scored since start; saturates at 2^32-1
- timeout_o  out  1  sticky watchdog flag (tied 0 without the macro)

## Operation
- States: IDLE, ISSUE, WAIT, SCORE_XOR, SCORE_CMP.
- IDLE, start_i=1 actions:
  - load nonce_seed_i into the nonce register;
  - set best_score_o=1024, best_nonce_o=0, hash_count_o=0;
  - clear found_o, timeout_o and the stop latch;
  - go to ISSUE.
- IDLE, other cases: stop_i in IDLE has no effect.
- ISSUE: assert core_start_o for exactly one cycle, then go to WAIT.
- WAIT: hold until core_ready_i=1, then capture core_hash_i and go to SCORE_XOR. core_ready_i is ignored in every other state.
- SCORE_XOR: register diff = captured hash XOR target_i.
- SCORE_CMP: score = popcount(diff).
  - If score < best_score_o (strict), update best_score_o/best_nonce_o. Ties keep the earlier nonce.
  - Increment hash_count_o, saturating.
  - Next state, in priority order:
    - score <= threshold_i: set found_o, go to IDLE.
    - stop latch set: go to IDLE.
    - otherwise: nonce += 1 mod 2^NONCE_W (all-ones wraps to 0), go to ISSUE.
- stop_i asserted in any non-IDLE state sets the stop latch. The in-flight hash is always completed and scored before the block stops.
- start_i while busy is ignored.

## Timing
- Reset values:
  - busy_o, core_start_o, found_o, timeout_o = 0;
  - best_score_o = 1024; best_nonce_o, core_nonce_o, hash_count_o = 0;
  - state = IDLE.
- Reset mid-operation returns all of the above in the next cycle. The stop latch clears. No further core_start_o is issued.
- start_i at cycle t: ISSUE at t+1, with core_start_o=1 in cycle t+1.
- core_ready_i seen in cycle r:
  - SCORE_XOR at r+1;
  - SCORE_CMP at r+2;
  - best/found/count outputs updated at r+3;
  - next core_start_o at r+3.
- Per-nonce overhead is 3 cycles plus core latency.
- core_ready_i in the same cycle the state enters WAIT (the cycle after ISSUE) is accepted.

## Configuration
- NONCE_SEARCH_TIMEOUT_EN defined:
  - a counter runs in WAIT and clears on entry to WAIT;
  - if it reaches TIMEOUT_CYCLES without core_ready_i, set timeout_o and go to IDLE;
  - best_* outputs are kept and no score is computed.
- NONCE_SEARCH_TIMEOUT_EN undefined: WAIT waits indefinitely, timeout_o is constant 0, and the counter logic is not present.

## Structure
- Package nonce_search_pkg holds:
  - state enum;
  - NONCE_W/HASH_W/SCORE_W defaults;
  - SCORE_INIT=1024.
- Sub-module popcount_1024: a combinational adder tree, 1024-bit in, 11-bit out, used in SCORE_CMP.

## Test plan
- Reset then idle: after rst_i, best_score_o=1024, busy_o=0; with start_i=0, core_start_o stays 0 for 100 cycles.
- Immediate hit:
  - stimulus: seed=5, target=0, threshold=1024, stub core returns hash 0 after 10 cycles;
  - response: found_o=1, best_nonce_o=5, best_score_o=0, hash_count_o=1, busy_o low 3 cycles after ready.
- Best tracking with ties:
  - stimulus: target=0, threshold=0, stub returns distances 9,4,4,7 for nonces 0..3, stop_i asserted during nonce 3;
  - response: best_score_o=4, best_nonce_o=1, hash_count_o=4, found_o=0.
- Nonce wrap: seed=2^256-1 with two hashes -> core_nonce_o sequence is all-ones, then 0.
- Stop/start races:
  - start_i while busy is ignored, checked by core_nonce_o continuity;
  - stop_i in IDLE is ignored, checked by a following start_i running normally;
  - rst_i mid-WAIT gives IDLE next cycle and core_ready_i afterwards is ignored.
- With NONCE_SEARCH_TIMEOUT_EN and TIMEOUT_CYCLES=16: stub never readies -> timeout_o=1 and busy_o=0 exactly 16 cycles after entering WAIT.
